draw_scheduler: RTL and testbench

//  Sequences a full puzzle-screen redraw over the single VGA plotter port: optional background clear,

---
 rtl/draw_scheduler_pkg.sv | 34 +++
 rtl/draw_scheduler_if.sv | 17 +
 rtl/draw_scheduler_clear_sweeper.sv | 66 ++++++
 rtl/draw_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_draw_scheduler.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/draw_scheduler_pkg.sv
// draw_scheduler_pkg
// Purpose: shared types and constants for the puzzle-screen redraw scheduler.
//   - state_t   : scheduler FSM states (CLEAR exists only when CLEAR_PHASE_EN is defined)
//   - *_DEF     : default screen size and grid-phase length
//   - BLACK/WHITE colour constants
//   - cnt_width : counter width helper that never returns zero
// Configuration macro: CLEAR_PHASE_EN
package draw_scheduler_pkg;

  localparam int SCREEN_W_DEF    = 160;
  localparam int SCREEN_H_DEF    = 120;
  localparam int GRID_CYCLES_DEF = 1280;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
`ifdef CLEAR_PHASE_EN
    ST_CLEAR,
`endif
    ST_GRID_RST,
    ST_GRID,
    ST_TILE_START,
    ST_TILE_WAIT,
    ST_DONE
  } state_t;

  // A count range of one still needs a one-bit register.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/draw_scheduler_if.sv
// draw_scheduler_if
// Purpose: the VGA plotter bus owned by the redraw scheduler.
// Signals:
//   vga_x     [7:0] plotter x coordinate
//   vga_y     [6:0] plotter y coordinate
//   vga_color [2:0] plotter colour
//   vga_plot        plotter write strobe
// Modports: master (scheduler drives the bus), slave (VGA adapter consumes it).
interface draw_scheduler_if;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_color;
  logic       vga_plot;

  modport master (output vga_x, output vga_y, output vga_color, output vga_plot);
  modport slave  (input  vga_x, input  vga_y, input  vga_color, input  vga_plot);
endinterface

// File: rtl/draw_scheduler_clear_sweeper.sv
// clear_sweeper
// Purpose: raster counter for the background clear sweep, x fastest, y slowest.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   start       reload the raster position to (0,0)
//   en          advance one pixel this cycle
//   x [7:0]     current column
//   y [6:0]     current row
//   last        current position is (SCREEN_W-1, SCREEN_H-1)
// Used only when CLEAR_PHASE_EN is defined.
module clear_sweeper
  import draw_scheduler_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       en,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       last
);

  localparam int XW = cnt_width(SCREEN_W);
  localparam int YW = cnt_width(SCREEN_H);
  localparam logic [XW-1:0] X_LAST = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_H - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  assign last = (x_q == X_LAST) && (y_q == Y_LAST);
  assign x    = 8'(x_q);
  assign y    = 7'(y_q);

  // Next raster position; the counter parks on the final pixel instead of wrapping.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (start) begin
      x_d = '0;
      y_d = '0;
    end else if (en && !last) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  // Raster position register.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler
// Purpose: sequences a full puzzle-screen redraw over the single VGA plotter:
//   optional background clear, then the grid drawer, then the tile drawer.
//   Only the active phase reaches the plotter; all plotter outputs are registered.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   redraw_req                        one-cycle redraw request
//   busy                              high while a redraw is in progress (incl. DONE)
//   redraw_done                       one-cycle pulse when the tile phase finishes
//   grid_rst / grid_en                grid drawer restart pulse / enable
//   grid_x, grid_y, grid_color        grid drawer pixel
//   tile_start                        one-cycle tile drawer start pulse
//   tile_plot, tile_x, tile_y, tile_color, tile_done   tile drawer pixel and finish
//   vga                               plotter bus (draw_scheduler_if.master)
// Configuration macro: CLEAR_PHASE_EN adds the CLEAR sweep with BG_COLOR.
module draw_scheduler
  import draw_scheduler_pkg::*;
#(
  parameter int GRID_CYCLES = GRID_CYCLES_DEF
`ifdef CLEAR_PHASE_EN
  ,
  parameter int          SCREEN_W = SCREEN_W_DEF,
  parameter int          SCREEN_H = SCREEN_H_DEF,
  parameter logic [2:0]  BG_COLOR = BLACK
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redraw_req,
  output logic                     busy,
  output logic                     redraw_done,
  output logic                     grid_rst,
  output logic                     grid_en,
  input  logic [7:0]               grid_x,
  input  logic [6:0]               grid_y,
  input  logic [2:0]               grid_color,
  output logic                     tile_start,
  input  logic                     tile_plot,
  input  logic [7:0]               tile_x,
  input  logic [6:0]               tile_y,
  input  logic [2:0]               tile_color,
  input  logic                     tile_done,
  draw_scheduler_if.master         vga
);

  localparam int GW = cnt_width(GRID_CYCLES);
  localparam logic [GW-1:0] GRID_LAST = GW'(GRID_CYCLES - 1);

`ifdef CLEAR_PHASE_EN
  localparam state_t FIRST_PHASE = ST_CLEAR;
`else
  localparam state_t FIRST_PHASE = ST_GRID_RST;
`endif

  state_t        state_q, state_d;
  logic          pending_q, pending_d;
  logic [GW-1:0] grid_cnt_q, grid_cnt_d;
  logic [7:0]    vga_x_q, vga_x_d;
  logic [6:0]    vga_y_q, vga_y_d;
  logic [2:0]    vga_color_q, vga_color_d;
  logic          vga_plot_q, vga_plot_d;

`ifdef CLEAR_PHASE_EN
  logic       sweep_start;
  logic       sweep_en;
  logic [7:0] sweep_x;
  logic [6:0] sweep_y;
  logic       sweep_last;

  clear_sweeper #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_sweeper (
    .clk   (clk),
    .reset (reset),
    .start (sweep_start),
    .en    (sweep_en),
    .x     (sweep_x),
    .y     (sweep_y),
    .last  (sweep_last)
  );
`endif

  assign vga.vga_x     = vga_x_q;
  assign vga.vga_y     = vga_y_q;
  assign vga.vga_color = vga_color_q;
  assign vga.vga_plot  = vga_plot_q;

  // Next-state and phase outputs. Coordinates hold outside the plotting phases,
  // while the strobe defaults low so idle clients can never reach the plotter.
  // Any request seen while busy collapses into the single pending flag; DONE
  // consumes it (or a same-cycle request) and restarts without passing IDLE.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    grid_cnt_d  = '0;
    vga_x_d     = vga_x_q;
    vga_y_d     = vga_y_q;
    vga_color_d = vga_color_q;
    vga_plot_d  = 1'b0;
    busy        = 1'b1;
    redraw_done = 1'b0;
    grid_rst    = 1'b0;
    grid_en     = 1'b0;
    tile_start  = 1'b0;
`ifdef CLEAR_PHASE_EN
    sweep_en    = 1'b0;
`endif

    if (state_q != ST_IDLE && redraw_req) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (redraw_req) begin
          state_d = FIRST_PHASE;
        end
      end
`ifdef CLEAR_PHASE_EN
      ST_CLEAR: begin
        sweep_en    = 1'b1;
        vga_x_d     = sweep_x;
        vga_y_d     = sweep_y;
        vga_color_d = BG_COLOR;
        vga_plot_d  = 1'b1;
        if (sweep_last) begin
          state_d = ST_GRID_RST;
        end
      end
`endif
      ST_GRID_RST: begin
        grid_rst = 1'b1;
        state_d  = ST_GRID;
      end
      ST_GRID: begin
        grid_en     = 1'b1;
        vga_x_d     = grid_x;
        vga_y_d     = grid_y;
        vga_color_d = grid_color;
        vga_plot_d  = 1'b1;
        if (grid_cnt_q == GRID_LAST) begin
          state_d = ST_TILE_START;
        end else begin
          grid_cnt_d = grid_cnt_q + GW'(1);
        end
      end
      ST_TILE_START: begin
        tile_start = 1'b1;
        state_d    = ST_TILE_WAIT;
      end
      ST_TILE_WAIT: begin
        vga_x_d     = tile_x;
        vga_y_d     = tile_y;
        vga_color_d = tile_color;
        vga_plot_d  = tile_plot;
        if (tile_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        redraw_done = 1'b1;
        pending_d   = 1'b0;
        state_d     = (pending_q || redraw_req) ? FIRST_PHASE : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef CLEAR_PHASE_EN
    sweep_start = (state_d == ST_CLEAR) && (state_q != ST_CLEAR);
`endif
  end

  // State, pending flag, grid counter and registered plotter outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pending_q   <= 1'b0;
      grid_cnt_q  <= '0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_color_q <= '0;
      vga_plot_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      grid_cnt_q  <= grid_cnt_d;
      vga_x_q     <= vga_x_d;
      vga_y_q     <= vga_y_d;
      vga_color_q <= vga_color_d;
      vga_plot_q  <= vga_plot_d;
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler
// Purpose: self-checking bench for draw_scheduler. A timeline model predicts,
//   from the redraw phase lengths alone, every scheduler output and the exact
//   plotter stream (clear raster, forwarded grid and tile pixels) one cycle late.
// Honours CLEAR_PHASE_EN the same way as the design.
module tb_draw_scheduler;
  import draw_scheduler_pkg::*;

  localparam int         W  = 160;
  localparam int         H  = 120;
  localparam int         G  = 1280;
  localparam logic [2:0] BG = 3'b000;
`ifdef CLEAR_PHASE_EN
  localparam int CL = W * H;
`else
  localparam int CL = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       redraw_req;
  logic       busy, redraw_done, grid_rst, grid_en, tile_start;
  logic [7:0] grid_x, tile_x;
  logic [6:0] grid_y, tile_y;
  logic [2:0] grid_color, tile_color;
  logic       tile_plot, tile_done;

  draw_scheduler_if vga_bus();

  draw_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .redraw_req  (redraw_req),
    .busy        (busy),
    .redraw_done (redraw_done),
    .grid_rst    (grid_rst),
    .grid_en     (grid_en),
    .grid_x      (grid_x),
    .grid_y      (grid_y),
    .grid_color  (grid_color),
    .tile_start  (tile_start),
    .tile_plot   (tile_plot),
    .tile_x      (tile_x),
    .tile_y      (tile_y),
    .tile_color  (tile_color),
    .tile_done   (tile_done),
    .vga         (vga_bus)
  );

  int checks = 0;
  int errors = 0;
  int doneCount = 0;

  always #5 clk = ~clk;

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge, where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random client traffic; the tile drawer follows its script only while the
  // scheduler is waiting on it, and otherwise emits noise including stray done pulses.
  task automatic applyStimulus(input bit inTileWait, input int k, input int tileLen);
    grid_x     = 8'($urandom_range(0, 159));
    grid_y     = 7'($urandom_range(0, 119));
    grid_color = 3'($urandom);
    tile_x     = 8'($urandom_range(0, 159));
    tile_y     = 7'($urandom_range(0, 119));
    tile_color = 3'($urandom);
    if (inTileWait) begin
      tile_plot = (k < tileLen) ? 1'b1 : 1'($urandom);
      tile_done = (k == tileLen);
    end else begin
      tile_plot = 1'($urandom);
      tile_done = ($urandom_range(0, 7) == 0);
    end
  endtask

  // Quiet period with client noise: nothing may reach the plotter or start a phase.
  task automatic checkIdle(input string tag, input int n);
    int errs = 0;
    for (int i = 0; i < n; i++) begin
      if (busy !== 1'b0 || vga_bus.vga_plot !== 1'b0 || grid_en !== 1'b0 ||
          grid_rst !== 1'b0 || tile_start !== 1'b0 || redraw_done !== 1'b0) errs++;
      applyStimulus(1'b0, 0, 0);
      redraw_req = 1'b0;
      tick();
    end
    checkOutput(tag, errs, 0);
  endtask

  // One redraw, entered with the sample of the cycle right after the accepting edge.
  // Timeline: CLEAR for CL cycles, one GRID_RST, G GRID cycles, one TILE_START,
  // TILE_WAIT until the scripted done, then DONE. The plotter shows one cycle later.
  task automatic runRedraw(input int tileLen, input int gridReqs, input bit doneReq, output bit restart);
    int tw = CL + G + 2;
    int doneC = tw + tileLen + 1;
    bit pending = 1'b0;
    bit expPlot = 1'b0;
    logic [7:0] expX = '0;
    logic [6:0] expY = '0;
    logic [2:0] expC = '0;
    int busyErr = 0, rstErr = 0, enErr = 0, tsErr = 0, rdErr = 0;
    int plotErr = 0, pixErr = 0;
    int clearPlots = 0, gridEnCycles = 0, tilePlots = 0, expTilePlots = 0;
    bit isClear, isGrst, isGrid, isTs, isTw, isDone;
    for (int c = 0; c <= doneC; c++) begin
      isClear = (c < CL);
      isGrst  = (c == CL);
      isGrid  = (c > CL) && (c <= CL + G);
      isTs    = (c == CL + G + 1);
      isTw    = (c >= tw) && (c < doneC);
      isDone  = (c == doneC);

      if (busy !== 1'b1) busyErr++;
      if (grid_rst !== isGrst) rstErr++;
      if (grid_en !== isGrid) enErr++;
      if (tile_start !== isTs) tsErr++;
      if (redraw_done !== isDone) rdErr++;
      if (redraw_done === 1'b1) doneCount++;
      if (grid_en === 1'b1) gridEnCycles++;
      if (vga_bus.vga_plot !== expPlot) plotErr++;
      else if (expPlot && (vga_bus.vga_x !== expX || vga_bus.vga_y !== expY ||
                           vga_bus.vga_color !== expC)) pixErr++;
      if (vga_bus.vga_plot === 1'b1 && c >= 1 && c <= CL && vga_bus.vga_color === BG) clearPlots++;
      if (vga_bus.vga_plot === 1'b1 && c > tw && c <= doneC) tilePlots++;

      applyStimulus(isTw, c - tw, tileLen);
      redraw_req = (isGrid && ((c - CL - 1) % 200 == 0) && ((c - CL - 1) / 200 < gridReqs)) ||
                   (isDone && doneReq);
      if (redraw_req) pending = 1'b1;

      if (isClear) begin
        expPlot = 1'b1; expX = 8'(c % W); expY = 7'(c / W); expC = BG;
      end else if (isGrid) begin
        expPlot = 1'b1; expX = grid_x; expY = grid_y; expC = grid_color;
      end else if (isTw) begin
        expPlot = tile_plot; expX = tile_x; expY = tile_y; expC = tile_color;
        if (tile_plot) expTilePlots++;
      end else begin
        expPlot = 1'b0;
      end
      tick();
    end
    redraw_req = 1'b0;
    checkOutput("busy", busyErr, 0);
    checkOutput("gridRst", rstErr, 0);
    checkOutput("gridEn", enErr, 0);
    checkOutput("tileStart", tsErr, 0);
    checkOutput("redrawDone", rdErr, 0);
    checkOutput("vgaPlot", plotErr, 0);
    checkOutput("vgaPixel", pixErr, 0);
    checkOutput("clearPlots", clearPlots, CL);
    checkOutput("gridEnCycles", gridEnCycles, G);
    checkOutput("tilePlots", tilePlots, expTilePlots);
    restart = pending;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit restart;
    reset      = 1'b1;
    redraw_req = 1'b0;
    applyStimulus(1'b0, 0, 0);
    repeat (3) tick();
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstPlot", vga_bus.vga_plot, 0);
    checkOutput("rstGridEn", grid_en, 0);
    checkOutput("rstTileStart", tile_start, 0);
    checkOutput("rstVgaXY", {vga_bus.vga_x, vga_bus.vga_y, vga_bus.vga_color}, 0);
    reset = 1'b0;
    checkIdle("idleAfterReset", 10);

    // Abort a redraw part-way (with a pending request) by reset.
    redraw_req = 1'b1;
    tick();
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'b0, 0, 0);
      redraw_req = (i == 300);
      tick();
    end
    redraw_req = 1'b0;
    reset = 1'b1;
    tick();
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstPlot", vga_bus.vga_plot, 0);
    checkOutput("midRstDone", redraw_done, 0);
    checkOutput("midRstGridEn", grid_en, 0);
    reset = 1'b0;
    checkIdle("idleAfterAbort", 20);

    // Fresh redraw with three collapsed requests during GRID, then a restart that
    // itself takes a request in its DONE cycle, then a plain final redraw.
    doneCount = 0;
    redraw_req = 1'b1;
    tick();
    redraw_req = 1'b0;
    runRedraw(5, 3, 1'b0, restart);
    if (restart) runRedraw($urandom_range(1, 8), 0, 1'b1, restart);
    if (restart) runRedraw($urandom_range(0, 6), 0, 1'b0, restart);
    checkOutput("doneTotal", doneCount, 3);
    checkIdle("idleAfterRedraws", 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
